// File: rtl/seq_detect_ctrl_if.sv
// Sequence-detector bus: start/stop control, scan configuration,
// serial data and status. master drives, slave is the detector.
interface seq_detect_ctrl_if #(
  parameter int PAT_W   = 8,
  parameter int CNT_W   = 8,
  parameter int FRAME_W = 16
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic               start;
  logic               stop;
  logic [PAT_W-1:0]   cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [FRAME_W-1:0] cfg_frame_len;
  logic [CNT_W-1:0]   cfg_thresh;
  logic               data_valid;
  logic               data_in;
  logic               busy;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic [FRAME_W-1:0] bit_cnt;
  logic               hit;
  logic               done;

  modport master (
    output start, stop, cfg_pattern, cfg_len,
    output cfg_frame_len, cfg_thresh,
    output data_valid, data_in,
    input  busy, match, match_cnt, bit_cnt,
    input  hit, done
  );

  modport slave (
    input  start, stop, cfg_pattern, cfg_len,
    input  cfg_frame_len, cfg_thresh,
    input  data_valid, data_in,
    output busy, match, match_cnt, bit_cnt,
    output hit, done
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Runtime-programmable serial pattern detector with start/stop scan
// sequencing, saturating match/bit counters and a sticky threshold hit.
// Ports: clk, rst_n (sync, active-low), bus (seq_detect_ctrl_if.slave).
// Macro SEQ_DET_OVERLAP_EN: defined = overlapping matches,
// undefined = fill is cleared on each match (non-overlapping).
module seq_detect_ctrl #(
  parameter int PAT_W   = 8,
  parameter int CNT_W   = 8,
  parameter int FRAME_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  seq_detect_ctrl_if.slave bus
);
  localparam int LEN_W = $clog2(PAT_W + 1);

`ifdef SEQ_DET_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE, ARM, SCAN, DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [PAT_W-1:0]   pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [FRAME_W-1:0] frame_q;
  logic [CNT_W-1:0]   thr_q;

  logic [PAT_W-1:0]   hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [FRAME_W-1:0] bit_q;
  logic               match_q;
  logic               hit_q;

  logic [LEN_W-1:0]   len_in;
  logic [PAT_W-1:0]   mask;
  logic [PAT_W-1:0]   hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic [FRAME_W-1:0] bit_n;
  logic [CNT_W-1:0]   cnt_n;
  logic               is_match;
  logic               last;

  // Length is clamped once at latch time so the scan never sees 0
  // or an over-long pattern.
  always_comb begin
    len_in = bus.cfg_len;
    unique case (1'b1)
      bus.cfg_len == '0:            len_in = LEN_W'(1);
      bus.cfg_len > LEN_W'(PAT_W):  len_in = LEN_W'(PAT_W);
      default: ;
    endcase
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++)
      mask[i] = (i < int'(len_q));
  end

  always_comb begin
    hist_n = {hist_q[PAT_W-2:0], bus.data_in};
    fill_n = (fill_q == LEN_W'(PAT_W)) ?
             fill_q : fill_q + LEN_W'(1);
    bit_n  = (&bit_q) ? bit_q : bit_q + FRAME_W'(1);
    cnt_n  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    is_match = bus.data_valid &&
               (((hist_n ^ pat_q) & mask) == '0) &&
               (fill_n >= len_q);
    last   = bus.data_valid && (frame_q != '0) &&
             (bit_n == frame_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.start) state_n = ARM;
      ARM:     state_n = SCAN;
      SCAN:    if (last || bus.stop) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q   <= '0;
      len_q   <= LEN_W'(1);
      frame_q <= '0;
      thr_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      match_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      match_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            pat_q   <= bus.cfg_pattern;
            len_q   <= len_in;
            frame_q <= bus.cfg_frame_len;
            thr_q   <= bus.cfg_thresh;
          end
        end
        ARM: begin
          hist_q <= '0;
          fill_q <= '0;
          cnt_q  <= '0;
          bit_q  <= '0;
          hit_q  <= 1'b0;
        end
        SCAN: begin
          if (bus.data_valid) begin
            hist_q <= hist_n;
            fill_q <= fill_n;
            bit_q  <= bit_n;
            if (is_match) begin
              match_q <= 1'b1;
              cnt_q   <= cnt_n;
              if (thr_q != '0 && cnt_n == thr_q)
                hit_q <= 1'b1;
              // Restart qualification so the next match
              // needs a full fresh pattern length.
              if (!OVERLAP) fill_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == ARM) || (state == SCAN);
  assign bus.done      = (state == DONE);
  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.bit_cnt   = bit_q;
  assign bus.hit       = hit_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed scenarios plus
// random scans compared each cycle against a bit-list reference model.
module tb_seq_detect_ctrl;
  localparam int PAT_W   = 8;
  localparam int CNT_W   = 3;
  localparam int FRAME_W = 8;
  localparam int LEN_W   = $clog2(PAT_W + 1);
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int FMAX    = (1 << FRAME_W) - 1;

`ifdef SEQ_DET_OVERLAP_EN
  localparam bit OV = 1'b1;
`else
  localparam bit OV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_detect_ctrl_if #(
    .PAT_W(PAT_W), .CNT_W(CNT_W), .FRAME_W(FRAME_W)
  ) bus ();

  seq_detect_ctrl #(
    .PAT_W(PAT_W), .CNT_W(CNT_W), .FRAME_W(FRAME_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h want=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 arm, 2 scan, 3 done.
  int ph = 0;
  int m_pat, m_len, m_frame, m_thr;
  int m_cnt = 0;
  int m_bits = 0;
  bit m_hit = 0;
  bit m_match = 0;
  int last_end = 0;
  int n;
  bit bits[$];

  function automatic int clamp_len(input int l);
    if (l == 0) return 1;
    if (l > PAT_W) return PAT_W;
    return l;
  endfunction

  // Last m_len received bits equal the pattern, newest bit = pattern
  // bit 0, and none of them belong to an earlier match when
  // overlapping is off.
  function automatic bit seen(input int sz);
    if (sz - last_end < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++)
      if (bits[sz-1-k] != ((m_pat >> k) & 1)) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      ph = 0; m_cnt = 0; m_bits = 0;
      m_hit = 0; m_match = 0;
    end else begin
      m_match = 0;
      case (ph)
        0: if (bus.start) begin
          m_pat   = int'(bus.cfg_pattern);
          m_len   = clamp_len(int'(bus.cfg_len));
          m_frame = int'(bus.cfg_frame_len);
          m_thr   = int'(bus.cfg_thresh);
          ph = 1;
        end
        1: begin
          bits.delete();
          last_end = 0; m_cnt = 0; m_bits = 0; m_hit = 0;
          ph = 2;
        end
        2: begin
          if (bus.data_valid) begin
            bits.push_back(bus.data_in);
            n = bits.size();
            if (m_bits < FMAX) m_bits++;
            if (seen(n)) begin
              m_match = 1;
              if (m_cnt < CMAX) m_cnt++;
              if (m_thr != 0 && m_cnt == m_thr) m_hit = 1;
              if (!OV) last_end = n;
            end
          end
          if ((bus.data_valid && m_frame != 0 &&
               m_bits == m_frame) || bus.stop)
            ph = 3;
        end
        default: ph = 0;
      endcase
    end
    #1;
    chk("busy", bus.busy, (ph == 1 || ph == 2));
    chk("done", bus.done, (ph == 3));
    chk("match", bus.match, m_match);
    chk("match_cnt", bus.match_cnt, m_cnt);
    chk("bit_cnt", bus.bit_cnt, m_bits);
    chk("hit", bus.hit, m_hit);
  end

  task automatic start_scan(input logic [PAT_W-1:0] p,
                            input logic [LEN_W-1:0] l,
                            input logic [FRAME_W-1:0] f,
                            input logic [CNT_W-1:0] t);
    bus.cfg_pattern   = p;
    bus.cfg_len       = l;
    bus.cfg_frame_len = f;
    bus.cfg_thresh    = t;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input logic s);
    bus.data_valid = 1'b1;
    bus.data_in    = b;
    bus.stop       = s;
    @(negedge clk);
    bus.data_valid = 1'b0;
    bus.stop       = 1'b0;
  endtask

  task automatic gap(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic send_stream(input logic [31:0] s, input int cnt);
    for (int i = cnt - 1; i >= 0; i--) send_bit(s[i], 1'b0);
  endtask

  task automatic wait_done(input int max);
    bit got;
    got = 0;
    for (int i = 0; i < max && !got; i++) begin
      if (bus.done) got = 1;
      else @(negedge clk);
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  int p, l, f, t, lim;
  bit fin;

  initial begin
    bus.start = 0; bus.stop = 0;
    bus.cfg_pattern = '0; bus.cfg_len = '0;
    bus.cfg_frame_len = '0; bus.cfg_thresh = '0;
    bus.data_valid = 0; bus.data_in = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cnt", bus.match_cnt, 0);
    chk("rst_hit", bus.hit, 0);

    // Reset in the middle of a scan
    start_scan(8'b1011, 4'd4, 8'd8, 3'd0);
    repeat (5) send_bit(1'b1, 1'b0);
    chk("mid_bits", bus.bit_cnt, 5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_busy", bus.busy, 0);
    chk("mid_cnt", bus.match_cnt, 0);
    chk("mid_done", bus.done, 0);
    @(negedge clk);
    chk("mid_done2", bus.done, 0);

    // Basic match
    start_scan(8'b1011, 4'd4, 8'd8, 3'd0);
    send_stream(32'b1011, 4);
    chk("basic_match", bus.match, 1);
    send_stream(32'b0000, 4);
    chk("basic_done", bus.done, 1);
    chk("basic_busy", bus.busy, 0);
    @(negedge clk);
    chk("basic_cnt", bus.match_cnt, 1);
    chk("basic_bits", bus.bit_cnt, 8);
    chk("basic_hit", bus.hit, 0);
    chk("model_basic", m_cnt, 1);

    // Overlap / non-overlap
    start_scan(8'b1011, 4'd4, 8'd7, 3'd0);
    send_stream(32'b1011011, 7);
    chk("ov_done", bus.done, 1);
    @(negedge clk);
    chk("ov_cnt", bus.match_cnt, OV ? 2 : 1);
    chk("model_ov", m_cnt, OV ? 2 : 1);

    // Threshold and counter saturation
    start_scan(8'b1, 4'd1, 8'd9, 3'd3);
    for (int i = 1; i <= 9; i++) begin
      send_bit(1'b1, 1'b0);
      if (i == 2) chk("thr_hit_lo", bus.hit, 0);
      if (i == 3) chk("thr_hit_hi", bus.hit, 1);
    end
    chk("thr_done", bus.done, 1);
    @(negedge clk);
    chk("thr_sat", bus.match_cnt, 7);
    chk("thr_bits", bus.bit_cnt, 9);
    chk("thr_hit", bus.hit, 1);
    chk("model_thr", m_cnt, 7);

    // Stop with gaps, unbounded frame
    start_scan(8'b101, 4'd3, 8'd0, 3'd0);
    send_bit(1'b1, 1'b0); gap(2);
    send_bit(1'b1, 1'b0); gap(1);
    send_bit(1'b0, 1'b0); gap(3);
    send_bit(1'b1, 1'b1);
    chk("stop_done", bus.done, 1);
    chk("stop_match", bus.match, 1);
    @(negedge clk);
    chk("stop_cnt", bus.match_cnt, 1);
    chk("stop_bits", bus.bit_cnt, 4);

    // Shadowed config, start ignored while busy and in DONE
    start_scan(8'b110, 4'd3, 8'd6, 3'd0);
    send_bit(1'b1, 1'b0);
    bus.cfg_pattern = 8'b1;
    bus.cfg_len = 4'd1;
    bus.cfg_frame_len = 8'd2;
    bus.start = 1'b1;
    send_stream(32'b10110, 5);
    chk("sh_done", bus.done, 1);
    @(negedge clk);
    bus.start = 1'b0;
    chk("sh_busy", bus.busy, 0);
    chk("sh_cnt", bus.match_cnt, 2);
    chk("sh_bits", bus.bit_cnt, 6);
    @(negedge clk);
    chk("sh_idle", bus.busy, 0);

    // bit_cnt saturation on an unbounded frame
    start_scan(8'b0, 4'd0, 8'd0, 3'd0);
    for (int i = 0; i < 259; i++)
      send_bit(1'($urandom_range(0, 1)), 1'b0);
    send_bit(1'b0, 1'b1);
    @(negedge clk);
    chk("bsat_bits", bus.bit_cnt, 255);
    chk("model_bsat", m_bits, 255);

    // Random scans
    repeat (40) begin
      p = int'($urandom);
      l = ($urandom_range(0, 7) == 0) ?
          int'($urandom_range(0, 15)) : int'($urandom_range(1, 3));
      f = int'($urandom_range(0, 20));
      t = int'($urandom_range(0, 7));
      start_scan(p[PAT_W-1:0], l[LEN_W-1:0],
                 f[FRAME_W-1:0], t[CNT_W-1:0]);
      lim = (f == 0) ? int'($urandom_range(5, 40)) : 3 * f + 10;
      fin = 0;
      for (int i = 0; i < lim && !fin; i++) begin
        if (bus.done) fin = 1;
        else begin
          bus.cfg_pattern = PAT_W'($urandom);
          bus.start = 1'($urandom_range(0, 1));
          bus.data_valid = ($urandom_range(0, 3) != 0);
          bus.data_in = 1'($urandom_range(0, 1));
          bus.stop = (i == lim - 1) ||
                     ($urandom_range(0, 40) == 0);
          @(negedge clk);
          bus.data_valid = 0;
          bus.stop = 0;
        end
      end
      bus.start = 0;
      if (!fin) wait_done(5);
      @(negedge clk);
      gap(int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
